// File: rtl/hwpf_issue_arb_pkg.sv
// Shared types and defaults for the prefetch issue arbiter.
// Line offset width, line-address type and issue FSM states.
package hwpf_pkg;
  localparam int HWPF_ADDR_W        = 40;
  localparam int HWPF_LINE_SIZE     = 64;
  localparam int HWPF_LINE_OFFSET_W = $clog2(HWPF_LINE_SIZE);

  typedef logic [HWPF_ADDR_W-1:0] hwpf_line_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } hwpf_issue_state_e;
endpackage

// File: rtl/hwpf_issue_arb_if.sv
// Prefetcher-side and dcache-side handshake bundle of the issue arbiter.
// slave = arbiter view, master = environment view.
interface hwpf_issue_arb_if
  import hwpf_pkg::*;
#(
  parameter int ADDR_WIDTH = HWPF_ADDR_W
);
  logic                  flush_i;
  logic                  pf_req_valid_i;
  logic                  pf_req_ready_o;
  logic [ADDR_WIDTH-1:0] pf_req_addr_i;
  logic                  cpu_busy_i;
  logic                  dc_req_valid_o;
  logic                  dc_req_ready_i;
  logic [ADDR_WIDTH-1:0] dc_req_addr_o;
  logic [15:0]           drop_cnt_o;

  modport slave (
    input  flush_i, pf_req_valid_i, pf_req_addr_i, cpu_busy_i, dc_req_ready_i,
    output pf_req_ready_o, dc_req_valid_o, dc_req_addr_o, drop_cnt_o
  );

  modport master (
    output flush_i, pf_req_valid_i, pf_req_addr_i, cpu_busy_i, dc_req_ready_i,
    input  pf_req_ready_o, dc_req_valid_o, dc_req_addr_o, drop_cnt_o
  );
endinterface

// File: rtl/hwpf_issue_arb_line_fifo.sv
// Circular line buffer; per-entry valid/addr exposed for a parallel dedup compare.
// Pointers carry one wrap bit so full/empty come from the MSB comparison.
module hwpf_line_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [W-1:0]              push_dat_i,
  input  logic                      pop_i,
  output logic [W-1:0]              head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DEPTH-1:0]          ent_vld_o,
  output logic [DEPTH-1:0][W-1:0]   ent_addr_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]              r_wr_ptr;
  logic [PW:0]              r_rd_ptr;
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][W-1:0]  r_mem;
  logic                     w_do_push;
  logic                     w_do_pop;

  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_o    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = push_i && !full_o && !flush_i;
  assign w_do_pop  = pop_i && !empty_o && !flush_i;

  assign head_o     = r_mem[r_rd_ptr[PW-1:0]];
  assign ent_vld_o  = r_vld;
  assign ent_addr_o = r_mem;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else begin
      if (w_do_pop) begin
        r_vld[r_rd_ptr[PW-1:0]] <= 1'b0;
        r_rd_ptr                <= r_rd_ptr + 1'b1;
      end
      if (w_do_push) begin
        r_vld[r_wr_ptr[PW-1:0]] <= 1'b1;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: r_vld qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= push_dat_i;
  end
endmodule

// File: rtl/hwpf_issue_arb.sv
// Buffers prefetch lines, drops duplicates and stale heads, and issues to the
// dcache prefetch port only in CPU-idle cycles; launch-to-valid is one cycle.
module hwpf_issue_arb
  import hwpf_pkg::*;
#(
  parameter int ADDR_WIDTH = HWPF_ADDR_W,
  parameter int LINE_SIZE  = HWPF_LINE_SIZE,
  parameter int DEPTH      = 4,
  parameter int STALL_MAX  = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  hwpf_issue_arb_if.slave  bus
);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_SIZE - 1));

  hwpf_issue_state_e               r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]           r_dc_addr;
  logic [SW-1:0]                   r_stall;
  logic [15:0]                     r_drop;

  logic [ADDR_WIDTH-1:0]           w_line;
  logic [ADDR_WIDTH-1:0]           w_head;
  logic                            w_full, w_empty;
  logic [DEPTH-1:0]                w_ent_vld;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] w_ent_addr;
  logic                            w_acc, w_dup_hit, w_dup_drop, w_push, w_pop;
  logic                            w_launch_ok, w_load, w_stall_inc, w_stall_hit;
  logic [1:0]                      w_drop_inc;
  logic [16:0]                     w_drop_sum;

  assign w_line = bus.pf_req_addr_i & LINE_MASK;

  hwpf_line_fifo #(.W(ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (bus.flush_i),
    .push_i     (w_push),
    .push_dat_i (w_line),
    .pop_i      (w_pop),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .ent_vld_o  (w_ent_vld),
    .ent_addr_o (w_ent_addr)
  );

  // The head still counts as a duplicate source in the cycle it is popped.
  always_comb begin
    w_dup_hit = (r_state == REQ) && (r_dc_addr == w_line);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_addr[i] == w_line)) w_dup_hit = 1'b1;
    end
  end

  assign bus.pf_req_ready_o = !w_full && !bus.flush_i;
  assign w_acc       = bus.pf_req_valid_i && bus.pf_req_ready_o;
  assign w_dup_drop  = w_acc && w_dup_hit;
  assign w_push      = w_acc && !w_dup_hit;
  assign w_launch_ok = !w_empty && !bus.cpu_busy_i && !bus.flush_i;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch_ok) begin
          w_load      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.dc_req_ready_i) begin
          if (w_launch_ok) w_load = 1'b1;
          else             w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_stall_inc = (r_state == IDLE) && !w_empty && bus.cpu_busy_i && !bus.flush_i;
  assign w_stall_hit = w_stall_inc && (r_stall == SW'(STALL_MAX - 1));
  assign w_pop       = w_load || w_stall_hit;
  assign w_drop_inc  = {1'b0, w_dup_drop} + {1'b0, w_stall_hit};
  assign w_drop_sum  = {1'b0, r_drop} + {15'd0, w_drop_inc};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_dc_addr <= '0;
      r_stall   <= '0;
      r_drop    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_dc_addr <= w_head;
      if (bus.flush_i || w_empty || !bus.cpu_busy_i || w_stall_hit) r_stall <= '0;
      else if (w_stall_inc)                                          r_stall <= r_stall + 1'b1;
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign bus.dc_req_valid_o = (r_state == REQ);
  assign bus.dc_req_addr_o  = r_dc_addr;
  assign bus.drop_cnt_o     = r_drop;
endmodule

// File: tb/tb_hwpf_issue_arb.sv
// Scoreboard bench for hwpf_issue_arb: expected issue lines are queued at
// stimulus time and matched against every dcache handshake.
module tb_hwpf_issue_arb;
  import hwpf_pkg::*;

  logic clk_i;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;
  hwpf_line_addr_t exp_q[$];

  hwpf_issue_arb_if bus();

  hwpf_issue_arb dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_line(input hwpf_line_addr_t a, input bit issue);
    hwpf_line_addr_t mask;
    mask = ~hwpf_line_addr_t'(63);
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_addr_i  = a;
    if (issue) exp_q.push_back(a & mask);
    tick();
    bus.pf_req_valid_i = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.dc_req_valid_o) break;
      tick();
    end
    chk(tag, {63'd0, bus.dc_req_valid_o}, 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !bus.dc_req_valid_o) break;
      tick();
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Every dcache handshake must match the next queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni && bus.dc_req_valid_o && bus.dc_req_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexp_issue", {63'd0, bus.dc_req_valid_o}, 64'd0);
      end else begin
        hwpf_line_addr_t e;
        e = exp_q.pop_front();
        chk("issue_addr", 64'(bus.dc_req_addr_o), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni             = 1'b0;
    bus.flush_i        = 1'b0;
    bus.pf_req_valid_i = 1'b0;
    bus.pf_req_addr_i  = '0;
    bus.cpu_busy_i     = 1'b0;
    bus.dc_req_ready_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_vld",  {63'd0, bus.dc_req_valid_o}, 64'd0);
    chk("rst_addr", 64'(bus.dc_req_addr_o), 64'd0);
    chk("rst_drop", 64'(bus.drop_cnt_o), 64'd0);
    chk("rst_rdy",  {63'd0, bus.pf_req_ready_o}, 64'd1);

    // Single request: valid two cycles after acceptance, aligned address.
    push_line(40'h10_0000_0043, 1'b1);
    chk("lat_n1", {63'd0, bus.dc_req_valid_o}, 64'd0);
    tick();
    chk("lat_n2", {63'd0, bus.dc_req_valid_o}, 64'd1);
    chk("lat_addr", 64'(bus.dc_req_addr_o), 64'h10_0000_0040);
    bus.dc_req_ready_i = 1'b1;
    tick();
    bus.dc_req_ready_i = 1'b0;
    chk("single_idle", {63'd0, bus.dc_req_valid_o}, 64'd0);
    chk("single_drop", 64'(bus.drop_cnt_o), 64'd0);

    // Dedup against a buffered line.
    bus.cpu_busy_i = 1'b1;
    push_line(40'h2000, 1'b1);
    push_line(40'h2010, 1'b0);
    push_line(40'h2040, 1'b1);
    chk("dedup_drop", 64'(bus.drop_cnt_o), 64'd1);
    chk("dedup_hold", {63'd0, bus.dc_req_valid_o}, 64'd0);
    bus.cpu_busy_i     = 1'b0;
    bus.dc_req_ready_i = 1'b1;
    drain("dedup_drain");
    bus.dc_req_ready_i = 1'b0;

    // Full FIFO, stall on the dcache side, then back-to-back issue.
    bus.cpu_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_line(40'h3000 + 40'(i * 64), 1'b1);
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_addr_i  = 40'h3100;
    #1;
    chk("full_rdy", {63'd0, bus.pf_req_ready_o}, 64'd0);
    tick();
    bus.pf_req_valid_i = 1'b0;
    bus.cpu_busy_i     = 1'b0;
    wait_vld("full_launch");
    for (int i = 0; i < 5; i++) begin
      bus.cpu_busy_i = i[0];
      tick();
      chk("hold_vld",  {63'd0, bus.dc_req_valid_o}, 64'd1);
      chk("hold_addr", 64'(bus.dc_req_addr_o), 64'h3000);
    end
    bus.cpu_busy_i     = 1'b0;
    bus.dc_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_vld", {63'd0, bus.dc_req_valid_o}, 64'd1);
      tick();
    end
    chk("b2b_end", {63'd0, bus.dc_req_valid_o}, 64'd0);
    bus.dc_req_ready_i = 1'b0;

    // Stale drop after exactly STALL_MAX busy cycles.
    bus.cpu_busy_i = 1'b1;
    push_line(40'h4000, 1'b0);
    repeat (14) tick();
    chk("stale_pre", 64'(bus.drop_cnt_o), 64'd1);
    tick();
    chk("stale_drop", 64'(bus.drop_cnt_o), 64'd2);

    // Dedup and stale drop in the same cycle count twice.
    push_line(40'h8000, 1'b0);
    repeat (14) tick();
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_addr_i  = 40'h8010;
    tick();
    bus.pf_req_valid_i = 1'b0;
    chk("dual_drop", 64'(bus.drop_cnt_o), 64'd4);

    // 14 busy cycles then one idle cycle: the line is issued.
    push_line(40'h4040, 1'b1);
    repeat (13) tick();
    bus.cpu_busy_i     = 1'b0;
    bus.dc_req_ready_i = 1'b1;
    drain("stale_escape");
    chk("stale_escape_drop", 64'(bus.drop_cnt_o), 64'd4);
    bus.dc_req_ready_i = 1'b0;
    repeat (3) tick();
    chk("empty_after_stale", {63'd0, bus.dc_req_valid_o}, 64'd0);

    // Flush with an outstanding REQ and three queued lines.
    bus.cpu_busy_i = 1'b1;
    push_line(40'h5000, 1'b1);
    push_line(40'h5040, 1'b0);
    push_line(40'h5080, 1'b0);
    push_line(40'h50c0, 1'b0);
    bus.cpu_busy_i = 1'b0;
    wait_vld("flush_launch");
    bus.flush_i        = 1'b1;
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_addr_i  = 40'h5100;
    #1;
    chk("flush_rdy", {63'd0, bus.pf_req_ready_o}, 64'd0);
    tick();
    bus.flush_i        = 1'b0;
    bus.pf_req_valid_i = 1'b0;
    chk("flush_req_kept", 64'(bus.dc_req_addr_o), 64'h5000);
    bus.dc_req_ready_i = 1'b1;
    drain("flush_drain");
    repeat (5) tick();
    chk("flush_no_more", {63'd0, bus.dc_req_valid_o}, 64'd0);
    chk("flush_drop", 64'(bus.drop_cnt_o), 64'd4);
    bus.dc_req_ready_i = 1'b0;

    // Asynchronous reset in the middle of a REQ.
    push_line(40'h6000, 1'b0);
    wait_vld("rst_launch");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_vld",  {63'd0, bus.dc_req_valid_o}, 64'd0);
    chk("arst_drop", 64'(bus.drop_cnt_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("arst_idle", {63'd0, bus.dc_req_valid_o}, 64'd0);
    chk("arst_rdy",  {63'd0, bus.pf_req_ready_o}, 64'd1);
    push_line(40'h7005, 1'b1);
    tick();
    chk("arst_new_vld",  {63'd0, bus.dc_req_valid_o}, 64'd1);
    chk("arst_new_addr", 64'(bus.dc_req_addr_o), 64'h7000);
    bus.dc_req_ready_i = 1'b1;
    drain("arst_drain");
    bus.dc_req_ready_i = 1'b0;
    chk("final_drop", 64'(bus.drop_cnt_o), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
